// File: rtl/hex_disp_pkg.sv
// Shared definitions for the multiplexed hex display driver.
//   ser_state_e : state encoding of the 74HC595 serializer FSM
//   SEG_BLANK   : active-low segment pattern with every segment dark
//   seg7_decode : hex nibble -> active-low segments, bit order g..a (bit 6 = g, bit 0 = a)
package hex_disp_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StShiftLo = 3'd2,
        StShiftHi = 3'd3,
        StLatch   = 3'd4
    } ser_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hc595_serializer.sv
// Shifts one W-bit word MSB first into a 74HC595 chain and latches it.
// Ports:
//   Clk, Rst_n : system clock, asynchronous active-low reset
//   start      : request a transfer (taken only in IDLE)
//   word       : word to send, sampled in the LOAD state
//   busy       : FSM not idle
//   done       : one-cycle pulse on the final LATCH cycle (LATCH -> IDLE)
//   SH_CP      : shift clock, high for SCLK_DIV cycles per bit
//   ST_CP      : latch clock, high for SCLK_DIV cycles after the last bit
//   DS         : serial data, only updated while SH_CP is low
module hc595_serializer
    import hex_disp_pkg::*;
#(
    parameter int unsigned W        = 16,
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         start,
    input  logic [W-1:0] word,
    output logic         busy,
    output logic         done,
    output logic         SH_CP,
    output logic         ST_CP,
    output logic         DS
);

    localparam int unsigned DivW = $clog2(SCLK_DIV + 1);
    localparam int unsigned BitW = $clog2(W + 1);

    ser_state_e     state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [BitW-1:0] bits_q, bits_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic            div_last;

    assign div_last = (div_q == DivW'(SCLK_DIV - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shreg_d = word;
                bits_d  = BitW'(W);
                div_d   = '0;
                state_d = StShiftLo;
            end
            StShiftLo: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StShiftHi;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShiftHi: begin
                if (div_last) begin
                    div_d  = '0;
                    bits_d = bits_q - 1'b1;
                    if (bits_q == BitW'(1)) begin
                        state_d = StLatch;
                    end else begin
                        // Shift on the falling SH_CP edge so DS is stable through the next rise
                        shreg_d = {shreg_q[W-2:0], 1'b0};
                        state_d = StShiftLo;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StLatch: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy  = (state_q != StIdle);
        done  = (state_q == StLatch) && div_last;
        SH_CP = (state_q == StShiftHi);
        ST_CP = (state_q == StLatch);
        DS    = shreg_q[W-1];
    end

endmodule

// File: rtl/hex_scan_595.sv
// Multiplexed hex 7-segment driver feeding a 74HC595 chain.
// Every SCAN_DIV cycles one digit word {dp_n, seg_n[6:0], sel[DIGITS-1:0]} is shifted out.
// Inputs are captured at the start of each digit-0 slot so a whole frame is coherent.
// Ports:
//   Clk, Rst_n  : system clock, asynchronous active-low reset
//   En          : 1 = display on, 0 = blank all digits (takes effect at next frame)
//   disp_data   : hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_mask     : 1 = light decimal point of digit i
//   blank_lz    : 1 = suppress leading zeros
//   SH_CP/ST_CP/DS : 595 shift clock, latch clock, serial data
//   frame_done  : one-cycle pulse when digit DIGITS-1 has been latched
module hex_scan_595
    import hex_disp_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned SCLK_DIV = 2,
    parameter int unsigned LZ_BLANK = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  En,
    input  logic [4*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    output logic                  SH_CP,
    output logic                  ST_CP,
    output logic                  DS,
    output logic                  frame_done
);

    localparam int unsigned W       = 8 + DIGITS;
    localparam int unsigned XferLen = 2 * SCLK_DIV * W + SCLK_DIV + 1;
    localparam int unsigned SlotW   = $clog2(SCAN_DIV + 1);
    localparam int unsigned IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
        $error("hex_scan_595: DIGITS must be 1..16");
    end
    if (SCLK_DIV < 1) begin : g_bad_sclk
        $error("hex_scan_595: SCLK_DIV must be >= 1");
    end
    if (XferLen >= SCAN_DIV) begin : g_bad_scan
        $error("hex_scan_595: digit transfer does not fit in one SCAN_DIV slot");
    end

    logic [SlotW-1:0]    slot_q, slot_d;
    logic [IdxW-1:0]     digit_q, digit_d;
    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   dp_q;
    logic                blz_q;
    logic                en_q;

    logic                slot_start;
    logic                ser_start;
    logic                ser_busy;
    logic                ser_done;
    logic                capture;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [DIGITS-1:0]   sel;
    logic                lz_run;
    logic                blank;
    logic [6:0]          seg_n;
    logic                dp_n;
    logic [W-1:0]        word;

    assign slot_start = (slot_q == '0);
    assign ser_start  = slot_start && !ser_busy;
    assign capture    = slot_start && (digit_q == '0);

    always_comb begin
        slot_d = (slot_q == SlotW'(SCAN_DIV - 1)) ? '0 : slot_q + 1'b1;
        digit_d = digit_q;
        if (ser_done) begin
            digit_d = (digit_q == IdxW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            slot_q  <= '0;
            digit_q <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            blz_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            digit_q <= digit_d;
            if (capture) begin
                data_q <= disp_data;
                dp_q   <= dp_mask;
                blz_q  <= blank_lz;
                en_q   <= En;
            end
        end
    end

    // lz_run stays set while every nibble and dp from the current digit upward is zero
    always_comb begin
        lz_run  = 1'b1;
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        sel     = '0;
        for (int j = 0; j < int'(DIGITS); j++) begin
            if (IdxW'(j) == digit_q) begin
                cur_nib = data_q[4*j +: 4];
                cur_dp  = dp_q[j];
                sel[j]  = 1'b1;
            end
            if (IdxW'(j) >= digit_q && (data_q[4*j +: 4] != 4'h0 || dp_q[j])) begin
                lz_run = 1'b0;
            end
        end
        blank = !en_q || ((LZ_BLANK != 0) && blz_q && (digit_q != '0) && lz_run);
        seg_n = blank ? SEG_BLANK : seg7_decode(cur_nib);
        dp_n  = blank ? 1'b1 : !cur_dp;
        word  = {dp_n, seg_n, sel};
    end

    hc595_serializer #(
        .W        (W),
        .SCLK_DIV (SCLK_DIV)
    ) u_ser (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (ser_start),
        .word  (word),
        .busy  (ser_busy),
        .done  (ser_done),
        .SH_CP (SH_CP),
        .ST_CP (ST_CP),
        .DS    (DS)
    );

    assign frame_done = ser_done && (digit_q == IdxW'(DIGITS - 1));

endmodule

// File: tb/tb_hex_scan_595.sv
module tb_hex_scan_595;

    localparam int unsigned DA  = 8;
    localparam int unsigned SDA = 200;
    localparam int unsigned DB  = 4;
    localparam int unsigned SDB = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        en, blank_lz, sh_cp, st_cp, ds, frame_done;
    logic [31:0] disp_data;
    logic [7:0]  dp_mask;

    logic        en_b, blz_b, sh_b, st_b, ds_b, fd_b;
    logic [15:0] data_b;
    logic [3:0]  dp_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hex_scan_595 #(.DIGITS(DA), .SCAN_DIV(SDA), .SCLK_DIV(2), .LZ_BLANK(1)) dut_a (
        .Clk(clk), .Rst_n(rst_n), .En(en), .disp_data(disp_data), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .SH_CP(sh_cp), .ST_CP(st_cp), .DS(ds), .frame_done(frame_done)
    );

    hex_scan_595 #(.DIGITS(DB), .SCAN_DIV(SDB), .SCLK_DIV(1), .LZ_BLANK(1)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .En(en_b), .disp_data(data_b), .dp_mask(dp_b),
        .blank_lz(blz_b), .SH_CP(sh_b), .ST_CP(st_b), .DS(ds_b), .frame_done(fd_b)
    );

    typedef struct {
        logic [23:0] word;
        int          nbits;
    } rx_t;

    rx_t         rx_a[$];
    rx_t         rx_b[$];
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];
    longint      fd_a_time[$];

    // Independent active-low hex font, g..a
    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [23:0] model(int nd, logic [63:0] data, logic [15:0] dp,
                                          logic blz, logic e, int idx);
        bit         lead = 1'b1;
        bit         blk;
        logic [6:0] seg;
        logic       dpn;
        for (int j = idx; j < nd; j++) begin
            if (data[4*j +: 4] != 4'h0 || dp[j]) lead = 1'b0;
        end
        blk = !e || (blz && idx != 0 && lead);
        seg = blk ? 7'h7F : font[data[4*idx +: 4]];
        dpn = blk ? 1'b1 : ~dp[idx];
        return (24'({dpn, seg}) << nd) | (24'(1) << idx);
    endfunction

    // Bus monitors: rebuild each latched word from SH_CP rises and ST_CP rises
    longint      cyc = 0;
    logic        shp_a = 0, stp_a = 0, fdp_a = 0, shp_b = 0, stp_b = 0;
    logic [23:0] shf_a = 0, shf_b = 0;
    int          nb_a = 0, nb_b = 0, fd_a_cnt = 0, fd_b_cnt = 0, fd_wide = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            shp_a <= 1'b0; stp_a <= 1'b0; fdp_a <= 1'b0; shf_a <= '0; nb_a <= 0;
            shp_b <= 1'b0; stp_b <= 1'b0; shf_b <= '0; nb_b <= 0;
        end else begin
            if (sh_cp && !shp_a) begin
                shf_a <= {shf_a[22:0], ds};
                nb_a  <= nb_a + 1;
            end
            if (st_cp && !stp_a) begin
                rx_a.push_back('{shf_a, nb_a});
                shf_a <= '0;
                nb_a  <= 0;
            end
            if (frame_done) begin
                fd_a_time.push_back(cyc);
                fd_a_cnt <= fd_a_cnt + 1;
            end
            if (frame_done && fdp_a) fd_wide <= fd_wide + 1;
            if (sh_b && !shp_b) begin
                shf_b <= {shf_b[22:0], ds_b};
                nb_b  <= nb_b + 1;
            end
            if (st_b && !stp_b) begin
                rx_b.push_back('{shf_b, nb_b});
                shf_b <= '0;
                nb_b  <= 0;
            end
            if (fd_b) fd_b_cnt <= fd_b_cnt + 1;
            shp_a <= sh_cp; stp_a <= st_cp; fdp_a <= frame_done;
            shp_b <= sh_b;  stp_b <= st_b;
        end
    end

    task automatic wait_fd_a(input string tag);
        int start = fd_a_cnt;
        int n = 0;
        while (fd_a_cnt == start && n < 4 * 8 * SDA) begin
            @(posedge clk);
            n++;
        end
        if (fd_a_cnt == start) begin
            total++; bad++;
            $display("FAIL %s: frame_done timeout after %0d cycles, required a pulse", tag, n);
        end
    endtask

    task automatic wait_fd_b(input string tag);
        int start = fd_b_cnt;
        int n = 0;
        while (fd_b_cnt == start && n < 4 * 4 * SDB) begin
            @(posedge clk);
            n++;
        end
        if (fd_b_cnt == start) begin
            total++; bad++;
            $display("FAIL %s: frame_done timeout after %0d cycles, required a pulse", tag, n);
        end
    endtask

    // Drive one frame's inputs on instance A and collect the resulting frame of words
    task automatic run_frame_a(input string tag, input logic [31:0] d, input logic [7:0] dp,
                               input logic blz, input logic e);
        wait_fd_a(tag);
        #1;
        disp_data = d; dp_mask = dp; blank_lz = blz; en = e;
        for (int i = 0; i < int'(DA); i++) exp_a.push_back(model(DA, {32'h0, d}, {8'h0, dp}, blz, e, i));
        rx_a.delete();
        wait_fd_a(tag);
    endtask

    task automatic test_reset();
        #3;
        total++; if (sh_cp !== 1'b0) begin bad++; $display("FAIL reset_sh: got %b want 0", sh_cp); end
        total++; if (st_cp !== 1'b0) begin bad++; $display("FAIL reset_st: got %b want 0", st_cp); end
        total++; if (ds !== 1'b0) begin bad++; $display("FAIL reset_ds: got %b want 0", ds); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        rx_t r;
        logic [23:0] e;
        run_frame_a("basic", 32'h1234ABCD, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < int'(DA); i++) begin
            e = exp_a.pop_front();
            total++;
            if (rx_a.size() == 0) begin
                bad++; $display("FAIL basic[%0d]: no word, want %h", i, e[15:0]);
            end else begin
                r = rx_a.pop_front();
                if (r.word[15:0] !== e[15:0] || r.nbits != 16) begin
                    bad++; $display("FAIL basic[%0d]: got %h/%0d bits want %h/16", i, r.word[15:0], r.nbits, e[15:0]);
                end
                if (i == 0) begin
                    total++;
                    if (r.word[15:0] !== 16'hA101) begin
                        bad++; $display("FAIL basic_d0: got %h want a101", r.word[15:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_lz(input string tag, input logic [7:0] dp);
        rx_t r;
        logic [23:0] e;
        run_frame_a(tag, 32'h00000050, dp, 1'b1, 1'b1);
        for (int i = 0; i < int'(DA); i++) begin
            e = exp_a.pop_front();
            total++;
            if (rx_a.size() == 0) begin
                bad++; $display("FAIL %s[%0d]: no word, want %h", tag, i, e[15:0]);
            end else begin
                r = rx_a.pop_front();
                if (r.word[15:0] !== e[15:0] || r.nbits != 16) begin
                    bad++; $display("FAIL %s[%0d]: got %h/%0d bits want %h/16", tag, i, r.word[15:0], r.nbits, e[15:0]);
                end
                // Hand-derived words for the interesting digits
                if (dp == 8'h00 && i == 0 && r.word[15:0] !== 16'hC001) begin
                    bad++; $display("FAIL %s_d0: got %h want c001", tag, r.word[15:0]);
                end
                if (dp == 8'h00 && i == 1 && r.word[15:0] !== 16'h9202) begin
                    bad++; $display("FAIL %s_d1: got %h want 9202", tag, r.word[15:0]);
                end
                if (dp == 8'h00 && i == 2 && r.word[15:0] !== 16'hFF04) begin
                    bad++; $display("FAIL %s_d2: got %h want ff04", tag, r.word[15:0]);
                end
                if (dp == 8'h08 && i == 3 && r.word[15:0] !== 16'h4008) begin
                    bad++; $display("FAIL %s_d3: got %h want 4008", tag, r.word[15:0]);
                end
                if (dp == 8'h08 && i == 4 && r.word[15:0] !== 16'hFF10) begin
                    bad++; $display("FAIL %s_d4: got %h want ff10", tag, r.word[15:0]);
                end
            end
        end
    endtask

    task automatic test_mid_frame();
        rx_t r;
        logic [23:0] e;
        int n = 0;
        wait_fd_a("midframe_sync");
        #1;
        disp_data = 32'h87654321; dp_mask = 8'h00; blank_lz = 1'b0; en = 1'b1;
        for (int i = 0; i < int'(DA); i++) exp_a.push_back(model(DA, 64'h87654321, 16'h0, 1'b0, 1'b1, i));
        rx_a.delete();
        while (rx_a.size() < 3 && n < 8 * SDA) begin
            @(posedge clk);
            n++;
        end
        #1 disp_data = 32'h0F0F0F0F;
        wait_fd_a("midframe_old");
        for (int i = 0; i < int'(DA); i++) begin
            e = exp_a.pop_front();
            total++;
            if (rx_a.size() == 0) begin
                bad++; $display("FAIL midframe_old[%0d]: no word, want %h", i, e[15:0]);
            end else begin
                r = rx_a.pop_front();
                if (r.word[15:0] !== e[15:0]) begin
                    bad++; $display("FAIL midframe_old[%0d]: got %h want %h", i, r.word[15:0], e[15:0]);
                end
            end
        end
        for (int i = 0; i < int'(DA); i++) exp_a.push_back(model(DA, 64'h0F0F0F0F, 16'h0, 1'b0, 1'b1, i));
        rx_a.delete();
        wait_fd_a("midframe_new");
        for (int i = 0; i < int'(DA); i++) begin
            e = exp_a.pop_front();
            total++;
            if (rx_a.size() == 0) begin
                bad++; $display("FAIL midframe_new[%0d]: no word, want %h", i, e[15:0]);
            end else begin
                r = rx_a.pop_front();
                if (r.word[15:0] !== e[15:0]) begin
                    bad++; $display("FAIL midframe_new[%0d]: got %h want %h", i, r.word[15:0], e[15:0]);
                end
            end
        end
    endtask

    task automatic test_frame_period();
        longint d;
        wait_fd_a("period");
        total++;
        if (fd_a_time.size() < 2) begin
            bad++; $display("FAIL period: only %0d frame_done pulses, want >=2", fd_a_time.size());
        end else begin
            d = fd_a_time[fd_a_time.size()-1] - fd_a_time[fd_a_time.size()-2];
            if (d != longint'(8 * SDA)) begin
                bad++; $display("FAIL period: got %0d cycles want %0d", d, 8 * SDA);
            end
        end
        total++;
        if (fd_wide != 0) begin
            bad++; $display("FAIL fd_width: got %0d multi-cycle pulses want 0", fd_wide);
        end
    endtask

    task automatic test_enable();
        rx_t r;
        logic [23:0] e;
        run_frame_a("enable", 32'h88888888, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < int'(DA); i++) begin
            e = exp_a.pop_front();
            total++;
            if (rx_a.size() == 0) begin
                bad++; $display("FAIL enable[%0d]: no word, want %h", i, e[15:0]);
            end else begin
                r = rx_a.pop_front();
                if (r.word[15:0] !== e[15:0] || r.word[15:8] !== 8'hFF) begin
                    bad++; $display("FAIL enable[%0d]: got %h want %h", i, r.word[15:0], e[15:0]);
                end
            end
        end
        #1 en = 1'b1;
    endtask

    task automatic test_small();
        rx_t r;
        logic [23:0] e;
        wait_fd_b("small_sync");
        #1;
        data_b = 16'h0A07; dp_b = 4'h0; blz_b = 1'b1; en_b = 1'b1;
        for (int i = 0; i < int'(DB); i++) exp_b.push_back(model(DB, 64'h0A07, 16'h0, 1'b1, 1'b1, i));
        rx_b.delete();
        wait_fd_b("small");
        for (int i = 0; i < int'(DB); i++) begin
            e = exp_b.pop_front();
            total++;
            if (rx_b.size() == 0) begin
                bad++; $display("FAIL small[%0d]: no word, want %h", i, e[11:0]);
            end else begin
                r = rx_b.pop_front();
                if (r.word[11:0] !== e[11:0] || r.nbits != 12) begin
                    bad++; $display("FAIL small[%0d]: got %h/%0d bits want %h/12", i, r.word[11:0], r.nbits, e[11:0]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        rx_t r;
        int n = 0;
        wait_fd_a("midreset_sync");
        repeat (SDA + 5) @(posedge clk);
        while (!sh_cp && n < 2 * SDA) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (!sh_cp) begin
            bad++; $display("FAIL midreset_arm: SH_CP never rose, want 1");
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (sh_cp !== 1'b0) begin bad++; $display("FAIL midreset_sh: got %b want 0", sh_cp); end
        total++; if (st_cp !== 1'b0) begin bad++; $display("FAIL midreset_st: got %b want 0", st_cp); end
        total++; if (ds !== 1'b0) begin bad++; $display("FAIL midreset_ds: got %b want 0", ds); end
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        rx_a.delete();
        n = 0;
        while (rx_a.size() == 0 && n < 2 * SDA) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (rx_a.size() == 0) begin
            bad++; $display("FAIL midreset_first: no word after reset, want sel 01");
        end else begin
            r = rx_a.pop_front();
            if (r.word[7:0] !== 8'h01 || r.nbits != 16) begin
                bad++; $display("FAIL midreset_first: got sel %h/%0d bits want 01/16", r.word[7:0], r.nbits);
            end
        end
    endtask

    initial begin
        en = 1'b1; blank_lz = 1'b0; disp_data = '0; dp_mask = '0;
        en_b = 1'b1; blz_b = 1'b0; data_b = '0; dp_b = '0;
        test_reset();
        test_basic();
        test_lz("lz", 8'h00);
        test_lz("lz_dp", 8'h08);
        test_mid_frame();
        test_frame_period();
        test_enable();
        test_small();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
